// File: rtl/ft245_pkg.sv
// ---------------------------------------------------------------------------
// ft245_pkg
// Shared definitions for the FT245 transmit arbiter slice: the arbiter FSM
// state encoding, the byte width of the FT245 data path and the default
// burst / timeout limits used as parameter defaults by ft245_tx_arbiter.
// No ports; imported with "import ft245_pkg::*;".
// ---------------------------------------------------------------------------
package ft245_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int BYTE_W            = 8;
   localparam int DEFAULT_MAX_BURST = 16;
   localparam int DEFAULT_TIMEOUT   = 255;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Scans the request vector starting
// at start_idx, wrapping from NUM_REQ-1 back to 0, and reports the first
// active requester as a one-hot vector plus its index.
//
// Ports:
//   req        in   NUM_REQ  active requests
//   start_idx  in   PTR_W    index at which the search begins (< NUM_REQ)
//   winner     out  NUM_REQ  one-hot winner, all-zero when no request
//   winner_idx out  PTR_W    binary index of the winner (0 when none)
//   any_req    out  1        at least one request is active
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   start_idx,
   output logic [NUM_REQ-1:0] winner,
   output logic [PTR_W-1:0]   winner_idx,
   output logic               any_req
);

   assign any_req = |req;

   // Walk the requesters in priority order beginning at start_idx. The sum is
   // held one bit wider than the pointer so the wrap test cannot overflow, and
   // the first hit found locks out every later candidate.
   always_comb begin
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      logic             found;
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      sum        = '0;
      idx        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, start_idx} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
         end
         idx = sum[PTR_W-1:0];
         if (!found && req[idx]) begin
            found       = 1'b1;
            winner[idx] = 1'b1;
            winner_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/ft245_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ft245_tx_arbiter
// Shares a single FT245 transmit byte path between NUM_REQ requesters. An
// owner is chosen round-robin and keeps the path until its packet ends, it
// has sent MAX_BURST bytes, or it stays silent for TIMEOUT cycles. Accepted
// bytes pass through a one-deep output register that drains on its own, so
// re-arbitration never waits for the FT245 side.
//
// Ports:
//   clk         in   1          system clock, rising edge
//   rst         in   1          synchronous active-high reset
//   req_data_i  in   8*NUM_REQ  requester k byte at [8k+7:8k]
//   req_rdy_i   in   NUM_REQ    requester k has a valid byte
//   req_last_i  in   NUM_REQ    requester k byte ends its packet
//   req_ack_o   out  NUM_REQ    requester k byte accepted this cycle
//   tx_data_si  out  8          byte towards the FT245 interface
//   tx_rdy_si   out  1          tx_data_si valid
//   tx_ack_si   in   1          FT245 interface accepted tx_data_si
//   grant_o     out  NUM_REQ    one-hot current owner, zero when none
//   busy_o      out  1          grant held or output byte pending
// ---------------------------------------------------------------------------
module ft245_tx_arbiter
   import ft245_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = DEFAULT_MAX_BURST,
   parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_rdy_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ack_o,
   output logic [BYTE_W-1:0]         tx_data_si,
   output logic                      tx_rdy_si,
   input  logic                      tx_ack_si,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      busy_o
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   arb_state_t         state;
   arb_state_t         state_next;
   logic               grant_load;
   logic               grant_release;

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_ptr_next;
   logic [NUM_REQ-1:0] winner;
   logic [PTR_W-1:0]   winner_idx;
   logic               any_req;

   logic [BEAT_W-1:0]  beat_cnt;
   logic [IDLE_W-1:0]  idle_cnt;

   logic               out_free;
   logic               owner_xfer;
   logic [BYTE_W-1:0]  owner_byte;
   logic               owner_last;
   logic               beat_at_max;
   logic               idle_at_max;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req        (req_rdy_i),
      .start_idx  (rr_ptr),
      .winner     (winner),
      .winner_idx (winner_idx),
      .any_req    (any_req)
   );

   // The output register can take a new byte when it is empty or when its
   // current byte leaves this very cycle, which is what allows one byte per
   // clock with tx_ack_si held high. Reset blocks any acknowledge so nothing
   // is accepted while the block is being cleared.
   assign out_free   = ~tx_rdy_si | tx_ack_si;
   assign req_ack_o  = (state == GRANT && !rst) ?
                       (grant_o & req_rdy_i & {NUM_REQ{out_free}}) : '0;
   assign owner_xfer = |req_ack_o;
   assign busy_o     = (state == GRANT) | tx_rdy_si;

   // Select the owner's byte and last flag with an AND-OR mux over the
   // one-hot grant, so no binary owner index has to be kept alongside it.
   always_comb begin
      owner_byte = '0;
      owner_last = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_o[k]) begin
            owner_byte = owner_byte | req_data_i[k*BYTE_W +: BYTE_W];
            owner_last = owner_last | req_last_i[k];
         end
      end
   end

   // Both limits are tested one step early: a transfer while the beat count
   // sits at MAX_BURST-1 is the MAX_BURST-th byte, and a silent cycle while
   // the idle count sits at TIMEOUT-1 is the TIMEOUT-th silent cycle. Either
   // way the grant drops on the edge that would have reached the limit.
   assign beat_at_max = (beat_cnt == BEAT_W'(MAX_BURST - 1));
   assign idle_at_max = (idle_cnt == IDLE_W'(TIMEOUT - 1));

   // The next search begins just after the requester being granted now.
   assign rr_ptr_next = (winner_idx == PTR_W'(NUM_REQ - 1)) ?
                        '0 : winner_idx + PTR_W'(1);

   // State register for the two-state arbitration FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. IDLE grants as soon as anybody is ready; GRANT holds
   // the path until the packet ends, the burst limit is hit, or the owner has
   // gone quiet for too long. A quiet owner keeps its lock in the meantime.
   always_comb begin
      state_next    = state;
      grant_load    = 1'b0;
      grant_release = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next = GRANT;
               grant_load = 1'b1;
            end
         end
         GRANT: begin
            if ((owner_xfer && (owner_last || beat_at_max)) ||
                (!owner_xfer && idle_at_max)) begin
               state_next    = IDLE;
               grant_release = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grant vector, round-robin pointer and the two per-grant counters. Both
   // counters restart whenever a grant starts or ends so each owner gets a
   // fresh burst and timeout allowance.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_o  <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         idle_cnt <= '0;
      end else if (grant_load) begin
         grant_o  <= winner;
         rr_ptr   <= rr_ptr_next;
         beat_cnt <= '0;
         idle_cnt <= '0;
      end else if (grant_release) begin
         grant_o  <= '0;
         beat_cnt <= '0;
         idle_cnt <= '0;
      end else if (state == GRANT) begin
         if (owner_xfer) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
         end
      end
   end

   // One-deep output register. A new byte always wins over the acknowledge
   // of the old one, so back-to-back transfers keep tx_rdy_si high, and the
   // byte is held untouched while the FT245 side stalls. Reset throws away
   // any pending byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_rdy_si  <= 1'b0;
         tx_data_si <= '0;
      end else if (owner_xfer) begin
         tx_rdy_si  <= 1'b1;
         tx_data_si <= owner_byte;
      end else if (tx_ack_si) begin
         tx_rdy_si  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ft245_tx_arbiter
// Directed self-checking bench for ft245_tx_arbiter with four requesters,
// MAX_BURST 16 and TIMEOUT 255. Inputs change on the falling edge and all
// outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ft245_tx_arbiter;

   localparam int NREQ  = 4;
   localparam int BURST = 16;
   localparam int TO    = 255;

   logic             clk;
   logic             rst;
   logic [8*NREQ-1:0] req_data_i;
   logic [NREQ-1:0]  req_rdy_i;
   logic [NREQ-1:0]  req_last_i;
   logic [NREQ-1:0]  req_ack_o;
   logic [7:0]       tx_data_si;
   logic             tx_rdy_si;
   logic             tx_ack_si;
   logic [NREQ-1:0]  grant_o;
   logic             busy_o;

   int tests_run;
   int tests_failed;

   ft245_tx_arbiter #(
      .NUM_REQ   (NREQ),
      .MAX_BURST (BURST),
      .TIMEOUT   (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_data_i (req_data_i),
      .req_rdy_i  (req_rdy_i),
      .req_last_i (req_last_i),
      .req_ack_o  (req_ack_o),
      .tx_data_si (tx_data_si),
      .tx_rdy_si  (tx_rdy_si),
      .tx_ack_si  (tx_ack_si),
      .grant_o    (grant_o),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic apply_reset();
      rst        = 1'b1;
      req_data_i = '0;
      req_rdy_i  = '0;
      req_last_i = '0;
      tx_ack_si  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      tests_run++;
      if ({grant_o, req_ack_o, tx_rdy_si, tx_data_si, busy_o} !== 18'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: grant=%b ack=%b rdy=%b data=%h busy=%b, want all zero",
                  grant_o, req_ack_o, tx_rdy_si, tx_data_si, busy_o);
      end
   endtask

   task automatic test_single();
      apply_reset();
      req_rdy_i  = 4'b0010;
      req_data_i = 32'h0000_A100;
      tx_ack_si  = 1'b1;
      #1;
      tests_run++;
      if ({grant_o, req_ack_o} !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL single_c0: grant=%b ack=%b, want 0000 0000", grant_o, req_ack_o);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({grant_o, req_ack_o, tx_rdy_si, busy_o} !== {4'b0010, 4'b0010, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL single_c1: grant=%b ack=%b rdy=%b busy=%b, want 0010 0010 0 1",
                  grant_o, req_ack_o, tx_rdy_si, busy_o);
      end
      @(negedge clk);
      req_data_i = 32'h0000_A200;
      #1;
      tests_run++;
      if ({req_ack_o, tx_rdy_si, tx_data_si} !== {4'b0010, 1'b1, 8'hA1}) begin
         tests_failed++;
         $display("[TB] FAIL single_c2: ack=%b rdy=%b data=%h, want 0010 1 a1",
                  req_ack_o, tx_rdy_si, tx_data_si);
      end
      @(negedge clk);
      req_data_i = 32'h0000_A300;
      req_last_i = 4'b0010;
      #1;
      tests_run++;
      if ({grant_o, req_ack_o, tx_rdy_si, tx_data_si} !== {4'b0010, 4'b0010, 1'b1, 8'hA2}) begin
         tests_failed++;
         $display("[TB] FAIL single_c3: grant=%b ack=%b rdy=%b data=%h, want 0010 0010 1 a2",
                  grant_o, req_ack_o, tx_rdy_si, tx_data_si);
      end
      @(negedge clk);
      req_rdy_i  = '0;
      req_last_i = '0;
      #1;
      tests_run++;
      if ({grant_o, req_ack_o, tx_rdy_si, tx_data_si} !== {4'b0000, 4'b0000, 1'b1, 8'hA3}) begin
         tests_failed++;
         $display("[TB] FAIL single_c4: grant=%b ack=%b rdy=%b data=%h, want 0000 0000 1 a3",
                  grant_o, req_ack_o, tx_rdy_si, tx_data_si);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({tx_rdy_si, busy_o} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL single_drain: rdy=%b busy=%b, want 0 0", tx_rdy_si, busy_o);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      apply_reset();
      req_rdy_i  = 4'b1111;
      req_last_i = 4'b1111;
      req_data_i = 32'h1312_1110;
      tx_ack_si  = 1'b1;
      #1;
      tests_run++;
      if (grant_o !== 4'b0000) begin
         tests_failed++;
         $display("[TB] FAIL rr_idle: grant=%b, want 0000", grant_o);
      end
      for (int i = 0; i < 5; i++) begin
         exp_g = 4'b0001 << (i % 4);
         @(negedge clk); #1;
         tests_run++;
         if ({grant_o, req_ack_o} !== {exp_g, exp_g}) begin
            tests_failed++;
            $display("[TB] FAIL rr_grant_%0d: grant=%b ack=%b, want %b %b",
                     i, grant_o, req_ack_o, exp_g, exp_g);
         end
         @(negedge clk); #1;
         tests_run++;
         if ({grant_o, tx_rdy_si, tx_data_si} !== {4'b0000, 1'b1, 8'h10 + 8'(i % 4)}) begin
            tests_failed++;
            $display("[TB] FAIL rr_release_%0d: grant=%b rdy=%b data=%h, want 0000 1 %h",
                     i, grant_o, tx_rdy_si, tx_data_si, 8'h10 + 8'(i % 4));
         end
      end
      req_rdy_i  = '0;
      req_last_i = '0;
   endtask

   task automatic test_burst();
      int bad;
      apply_reset();
      req_rdy_i  = 4'b0101;
      req_last_i = 4'b0100;
      req_data_i = 32'h00C2_0030;
      tx_ack_si  = 1'b1;
      #1;
      bad = 0;
      for (int b = 0; b < 16; b++) begin
         @(negedge clk);
         req_data_i[7:0] = 8'h30 + 8'(b);
         #1;
         if ({grant_o, req_ack_o} !== {4'b0001, 4'b0001}) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("[TB] FAIL burst_owner0: %0d of 16 cycles wrong, want grant 0001 ack 0001", bad);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({grant_o, req_ack_o, tx_data_si} !== {4'b0000, 4'b0000, 8'h3F}) begin
         tests_failed++;
         $display("[TB] FAIL burst_limit: grant=%b ack=%b data=%h, want 0000 0000 3f",
                  grant_o, req_ack_o, tx_data_si);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({grant_o, req_ack_o} !== {4'b0100, 4'b0100}) begin
         tests_failed++;
         $display("[TB] FAIL burst_switch: grant=%b ack=%b, want 0100 0100", grant_o, req_ack_o);
      end
      @(negedge clk);
      req_rdy_i[2]    = 1'b0;
      req_data_i[7:0] = 8'h40;
      #1;
      tests_run++;
      if ({grant_o, tx_data_si} !== {4'b0000, 8'hC2}) begin
         tests_failed++;
         $display("[TB] FAIL burst_req2_done: grant=%b data=%h, want 0000 c2", grant_o, tx_data_si);
      end
      bad = 0;
      for (int b = 16; b < 20; b++) begin
         @(negedge clk);
         req_data_i[7:0] = 8'h30 + 8'(b);
         req_last_i[0]   = (b == 19);
         #1;
         if ({grant_o, req_ack_o} !== {4'b0001, 4'b0001}) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("[TB] FAIL burst_resume: %0d of 4 cycles wrong, want grant 0001 ack 0001", bad);
      end
      @(negedge clk);
      req_rdy_i  = '0;
      req_last_i = '0;
      #1;
      tests_run++;
      if ({grant_o, tx_data_si} !== {4'b0000, 8'h43}) begin
         tests_failed++;
         $display("[TB] FAIL burst_end: grant=%b data=%h, want 0000 43", grant_o, tx_data_si);
      end
   endtask

   task automatic test_stall();
      apply_reset();
      req_rdy_i  = 4'b0010;
      req_data_i = 32'h0000_5500;
      tx_ack_si  = 1'b0;
      @(negedge clk); #1;
      tests_run++;
      if ({grant_o, req_ack_o, tx_rdy_si} !== {4'b0010, 4'b0010, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL stall_grant: grant=%b ack=%b rdy=%b, want 0010 0010 0",
                  grant_o, req_ack_o, tx_rdy_si);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_data_i = 32'h0000_6600;
         req_last_i = 4'b0010;
         #1;
         tests_run++;
         if ({req_ack_o, tx_rdy_si, tx_data_si} !== {4'b0000, 1'b1, 8'h55}) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold_%0d: ack=%b rdy=%b data=%h, want 0000 1 55",
                     c, req_ack_o, tx_rdy_si, tx_data_si);
         end
      end
      @(negedge clk);
      tx_ack_si = 1'b1;
      #1;
      tests_run++;
      if ({req_ack_o, tx_data_si} !== {4'b0010, 8'h55}) begin
         tests_failed++;
         $display("[TB] FAIL stall_release: ack=%b data=%h, want 0010 55", req_ack_o, tx_data_si);
      end
      @(negedge clk);
      req_rdy_i  = '0;
      req_last_i = '0;
      #1;
      tests_run++;
      if ({grant_o, tx_rdy_si, tx_data_si} !== {4'b0000, 1'b1, 8'h66}) begin
         tests_failed++;
         $display("[TB] FAIL stall_next: grant=%b rdy=%b data=%h, want 0000 1 66",
                  grant_o, tx_rdy_si, tx_data_si);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({tx_rdy_si, busy_o} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL stall_drain: rdy=%b busy=%b, want 0 0", tx_rdy_si, busy_o);
      end
   endtask

   task automatic test_timeout();
      int bad;
      apply_reset();
      req_rdy_i  = 4'b0001;
      req_data_i = 32'h0000_0077;
      tx_ack_si  = 1'b1;
      @(negedge clk); #1;
      tests_run++;
      if ({grant_o, req_ack_o} !== {4'b0001, 4'b0001}) begin
         tests_failed++;
         $display("[TB] FAIL timeout_grant: grant=%b ack=%b, want 0001 0001", grant_o, req_ack_o);
      end
      bad = 0;
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         if (i == 0) begin
            req_rdy_i  = 4'b1000;
            req_last_i = 4'b1000;
            req_data_i = 32'h3C00_0000;
         end
         #1;
         if ({grant_o, req_ack_o} !== {4'b0001, 4'b0000}) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_hold: %0d of %0d cycles wrong, want grant 0001 ack 0000", bad, TO);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({grant_o, req_ack_o} !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL timeout_release: grant=%b ack=%b, want 0000 0000", grant_o, req_ack_o);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({grant_o, req_ack_o} !== {4'b1000, 4'b1000}) begin
         tests_failed++;
         $display("[TB] FAIL timeout_next: grant=%b ack=%b, want 1000 1000", grant_o, req_ack_o);
      end
      @(negedge clk);
      req_rdy_i  = '0;
      req_last_i = '0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req_rdy_i  = 4'b0010;
      req_data_i = 32'h0000_9900;
      tx_ack_si  = 1'b0;
      @(negedge clk); #1;
      tests_run++;
      if (grant_o !== 4'b0010) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_grant: grant=%b, want 0010", grant_o);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if ({tx_rdy_si, tx_data_si} !== {1'b1, 8'h99}) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_pending: rdy=%b data=%h, want 1 99", tx_rdy_si, tx_data_si);
      end
      @(negedge clk);
      rst        = 1'b0;
      req_rdy_i  = 4'b0101;
      req_last_i = 4'b0101;
      req_data_i = 32'h00A2_00A0;
      tx_ack_si  = 1'b1;
      #1;
      tests_run++;
      if ({grant_o, req_ack_o, tx_rdy_si, tx_data_si, busy_o} !== 18'h0) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_cleared: grant=%b ack=%b rdy=%b data=%h busy=%b, want all zero",
                  grant_o, req_ack_o, tx_rdy_si, tx_data_si, busy_o);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({grant_o, req_ack_o, tx_rdy_si} !== {4'b0001, 4'b0001, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_regrant: grant=%b ack=%b rdy=%b, want 0001 0001 0",
                  grant_o, req_ack_o, tx_rdy_si);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({tx_rdy_si, tx_data_si} !== {1'b1, 8'hA0}) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_byte: rdy=%b data=%h, want 1 a0", tx_rdy_si, tx_data_si);
      end
      req_rdy_i  = '0;
      req_last_i = '0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      req_data_i   = '0;
      req_rdy_i    = '0;
      req_last_i   = '0;
      tx_ack_si    = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_burst();
      test_stall();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ft245_tx_arbiter.md
FT245_TX_ARBITER -- requirements
Module: ft245_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FT245 TX path (2..8).
REQ-002 Parameter MAX_BURST, default 16: maximum bytes per grant before forced re-arbitration.
REQ-003 Parameter TIMEOUT, default 255: idle cycles within a held grant before forced release.
REQ-004 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_data_i  input  8*NUM_REQ  packed bytes; requester k at bits [8k+7:8k].
REQ-007 req_rdy_i  input  NUM_REQ  requester k has a valid byte.
REQ-008 req_last_i  input  NUM_REQ  requester k's current byte ends its packet.
REQ-009 req_ack_o  output  NUM_REQ  byte of requester k accepted this cycle.
REQ-010 tx_data_si  output  8  byte to FT245 interface.
REQ-011 tx_rdy_si  output  1  tx_data_si valid.
REQ-012 tx_ack_si  input  1  FT245 interface accepted tx_data_si.
REQ-013 grant_o  output  NUM_REQ  one-hot current owner; all-zero when none.
REQ-014 busy_o  output  1  grant held or output byte pending.

Function
REQ-015 A transfer occurs on any cycle where rdy and ack are both high, on either side.
REQ-016 FSM states: IDLE (no grant), GRANT (owner holds path); output register tracked separately by tx_rdy_si.
REQ-017 IDLE: if any req_rdy_i high, next edge sets grant_o to the round-robin winner and enters GRANT; otherwise remain.
REQ-018 Round-robin: search starts at index after the last granted requester, wrapping NUM_REQ-1 -> 0; after reset the search starts at 0.
REQ-019 In GRANT, req_ack_o[g] = grant_o[g] & req_rdy_i[g] & (~tx_rdy_si | tx_ack_si); combinational, all other req_ack_o bits zero.
REQ-020 On a requester transfer, the byte loads into the output register and tx_rdy_si is set at the next edge.
REQ-021 tx_rdy_si clears on tx_ack_si unless a new byte loads the same cycle; tx_data_si is stable while tx_rdy_si is high and tx_ack_si is low.
REQ-022 Throughput: one byte per cycle sustained when owner rdy and tx_ack_si are continuously high.
REQ-023 Beat counter (width clog2(MAX_BURST+1)) clears on grant and increments per requester transfer.
REQ-024 Grant releases (-> IDLE, grant_o zero) at the edge following a transfer with req_last_i[g] high or beat count reaching MAX_BURST.
REQ-025 Idle counter clears on each owner transfer, increments each GRANT cycle without one; at TIMEOUT the grant releases.
REQ-026 Release does not wait for the output register; a pending byte drains independently while IDLE re-arbitrates.
REQ-027 Latency: req_rdy_i high in IDLE at cycle 0 -> grant_o at cycle 1, req_ack_o at cycle 1, tx_rdy_si at cycle 2.
REQ-028 Simultaneous requests in IDLE: exactly one winner per REQ-018; losers see req_ack_o low and must hold data.
REQ-029 Owner dropping req_rdy_i mid-packet keeps the grant (packet lock) subject to REQ-025.
REQ-030 busy_o = (state == GRANT) | tx_rdy_si.

Reset
REQ-031 On rst: state IDLE, grant_o 0, req_ack_o 0, tx_rdy_si 0, tx_data_si 8'h00, busy_o 0, counters 0, round-robin pointer to 0.
REQ-032 rst mid-packet discards any pending output byte; no tx_rdy_si pulse in the cycle following reset.

Structure
REQ-033 Shared package ft245_pkg holds state encodings (IDLE, GRANT), byte width 8 and default MAX_BURST/TIMEOUT constants.
REQ-034 One sub-module, rr_arbiter: combinational request vector plus last-grant pointer -> one-hot winner.

Verification
REQ-035 Single requester 1 sends 3 bytes 8'hA1,8'hA2,8'hA3 (last on third), tx_ack_si held high -> bytes appear in order on consecutive cycles from cycle 2, grant_o=4'b0010 then 0.
REQ-036 All four rdy in IDLE after reset, each 1-byte packets -> grant order 0,1,2,3, then 0 again.
REQ-037 Requester 0 streams 20 bytes without last, MAX_BURST=16, requester 2 waiting -> grant switches to 2 after 16th byte; requester 0 resumes afterwards.
REQ-038 tx_ack_si low for 5 cycles with byte 8'h55 pending -> tx_data_si stays 8'h55, req_ack_o all 0, then one transfer on ack.
REQ-039 Owner drops rdy mid-packet for TIMEOUT cycles -> grant_o zero at timeout, pending requester granted next cycle.
REQ-040 rst asserted with tx_rdy_si high mid-packet -> all outputs at reset values next edge; next grant starts at requester 0.
